rgbw_fade_ramp: RTL and testbench
=================================

# rgbw_fade_ramp

Duty slew limiter between the colour generator and the four-channel PWM generator of the RGBW lamp. It takes the colour generator's red/green/blue/white duty targets and moves its registered duty outputs toward them one bounded step at a time, at a programmable rate. This gives smooth fades and a soft-start after reset instead of abrupt jumps on every SPI update. When fading is disabled it is a one-cycle register stage.

## Interface
Parameters:
- PRESC, 1200, clk12 cycles per base tick (10 kHz at 12 MHz); must be ≥2.
- STEP, 1, maximum duty change per step per channel, 1..255.

Ports:
- clk12  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fade_en  in  1  1 = ramp toward targets, 0 = track targets directly.
- rate  in  8  step interval select: one step every (rate+1)*PRESC cycles.
- red_tgt, green_tgt, blue_tgt, white_tgt  in  8 each  duty targets from colour generator.
- red_duty, green_duty, blue_duty, white_duty  out  8 each  registered duties to PWM generator.
- settled  out  1  registered; 1 when state is SETTLED.
- blank  in  1  present only with RGBW_FADE_BLANK_EN (see Configuration).

## Operation
- Effective target per channel: *_tgt (or 0 when blanked).
- match = all four duties equal their effective targets (combinational, current duties vs current inputs).
- Prescaler pcnt counts 0..PRESC-1; tick when pcnt = PRESC-1, then wraps to 0.
- Rate counter rcnt counts ticks; step = tick AND rcnt ≥ rate; rcnt clears on step, else increments on tick. The ≥ compare makes a lowered rate take effect at the next tick with no wrap-around.
- State SETTLED: counters held at 0. If fade_en=1 and !match → RAMPING, counters cleared.
- State RAMPING: counters run. On step, each channel independently: if duty < tgt, duty += min(STEP, tgt−duty); if duty > tgt, duty −= min(STEP, duty−tgt); else hold. Differences computed 9-bit; never overshoot, never wrap. When match at an edge (evaluated before the update) → SETTLED.
- Target change mid-ramp: ramp continues from current duty toward new target; counters are not reset; direction reversal is allowed.
- fade_en=0: every edge duty <= effective target, state forced SETTLED, counters cleared. Switching fade_en 1→0 mid-ramp jumps to target at the next edge. Switching 0→1 causes no output change.
- Reset: all duties 0, settled 1, state SETTLED, pcnt 0, rcnt 0. Nonzero targets after reset with fade_en=1 produce a soft-start ramp from 0.

## Timing
- Targets change before edge k (fade_en=1, SETTLED) → at edge k: RAMPING, settled=0.
- First step is at edge k+(rate+1)*PRESC; subsequent steps follow every (rate+1)*PRESC cycles.
- settled returns to 1 at the first edge after the last step.
- fade_en=0 latency: 1 cycle input→duty; settled stays 1.
- Reset is asynchronous assert. Deassertion is synchronized externally (reset_sync domain).

## Configuration
- RGBW_FADE_BLANK_EN defined: adds input blank. While blank=1, every effective target is 0, so duties ramp to 0 (or jump to 0 with fade_en=0). On release, duties ramp back to *_tgt. Same state/counter rules apply.
- Undefined: no blank port; effective target is always *_tgt.

## Test plan
- PRESC=4, STEP=1, rate=0, fade_en=1. Release reset with red_tgt=3, others 0 → red_duty 1,2,3 at cycles 4,8,12 after reset release; settled 0 during the ramp, 1 at cycle 13.
- STEP=4, red settled at 10, then red_tgt=0 → red_duty 6,2,0 on successive steps (no wrap to 254).
- fade_en=0, green_tgt=200 → green_duty=200 after one edge; settled constantly 1. Toggle fade_en 1→0 mid-ramp → jump to target next edge.
- Mid-ramp reversal: blue ramping 0→50, at blue=20 set blue_tgt=10 → next steps 19,18,…,10, then settled=1.
- rate=3, PRESC=4 → steps every 16 cycles. Change rate to 0 while rcnt=2 → step at the next tick.
- With RGBW_FADE_BLANK_EN: all channels at 8, blank=1 → all ramp to 0. Release blank → all ramp back to 8. Assert reset mid-ramp → all duties 0 immediately, settled=1.

Source files
------------

// File: rtl/rgbw_fade_ramp.sv
// -----------------------------------------------------------------------------
// rgbw_fade_ramp
//
// Duty slew limiter between the colour generator and the four-channel PWM
// generator. Registered duties move toward their targets by at most STEP per
// step, one step every (rate+1)*PRESC clock cycles. With fade_en low the block
// is a plain one-cycle register stage.
//
// Optional feature macro: RGBW_FADE_BLANK_EN adds the 'blank' input, which
// forces every effective target to 0 while high.
//
// Ports:
//   clk12                      system clock, all state on rising edge
//   reset                      asynchronous, active-high reset
//   fade_en                    1 = ramp toward targets, 0 = track directly
//   rate[7:0]                  step interval select
//   red/green/blue/white_tgt   duty targets (8 bit each)
//   blank                      (RGBW_FADE_BLANK_EN only) force targets to 0
//   red/green/blue/white_duty  registered duties to the PWM generator
//   settled                    registered, 1 while not ramping
//
// Handshake: none; inputs are level-sampled on every rising edge.
// -----------------------------------------------------------------------------
module rgbw_fade_ramp #(
    parameter int PRESC = 1200,
    parameter int STEP  = 1
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic       fade_en,
    input  logic [7:0] rate,
    input  logic [7:0] red_tgt,
    input  logic [7:0] green_tgt,
    input  logic [7:0] blue_tgt,
    input  logic [7:0] white_tgt,
`ifdef RGBW_FADE_BLANK_EN
    input  logic       blank,
`endif
    output logic [7:0] red_duty,
    output logic [7:0] green_duty,
    output logic [7:0] blue_duty,
    output logic [7:0] white_duty,
    output logic       settled
);

    localparam int            PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESC - 1);
    localparam logic [8:0]    STEP9    = 9'(STEP);

    localparam logic [0:0] ST_SETTLED = 1'b0;
    localparam logic [0:0] ST_RAMPING = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          settled_q, settled_d;
    logic [7:0]    duty_q [4];
    logic [7:0]    duty_d [4];
    logic [7:0]    tgt_raw [4];
    logic [7:0]    tgt_eff [4];
    logic          match;
    logic          tick;
    logic          step;

    assign tgt_raw[0] = red_tgt;
    assign tgt_raw[1] = green_tgt;
    assign tgt_raw[2] = blue_tgt;
    assign tgt_raw[3] = white_tgt;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
`ifdef RGBW_FADE_BLANK_EN
            tgt_eff[i] = blank ? 8'd0 : tgt_raw[i];
`else
            tgt_eff[i] = tgt_raw[i];
`endif
        end
    end

    // One bounded move toward the target. The 9-bit difference is clamped to
    // STEP, so the result lands on or short of the target and never wraps.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        slew = cur;
        diff = 9'd0;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            if (diff > STEP9) diff = STEP9;
            slew = 8'({1'b0, cur} + diff);
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            if (diff > STEP9) diff = STEP9;
            slew = 8'({1'b0, cur} - diff);
        end
    endfunction

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (duty_q[i] != tgt_eff[i]) match = 1'b0;
        end
    end

    // '>=' rather than '==' so a rate lowered below the current count still
    // steps on the next tick instead of waiting for an 8-bit wrap.
    assign tick = (pcnt_q == PCNT_MAX);
    assign step = tick && (rcnt_q >= rate);

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        rcnt_d  = rcnt_q;
        for (int i = 0; i < 4; i++) duty_d[i] = duty_q[i];

        if (!fade_en) begin
            for (int i = 0; i < 4; i++) duty_d[i] = tgt_eff[i];
            state_d = ST_SETTLED;
            pcnt_d  = '0;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                ST_SETTLED: begin
                    pcnt_d = '0;
                    rcnt_d = '0;
                    if (!match) state_d = ST_RAMPING;
                end
                ST_RAMPING: begin
                    if (match) begin
                        state_d = ST_SETTLED;
                        pcnt_d  = '0;
                        rcnt_d  = '0;
                    end else begin
                        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
                        if (step) begin
                            rcnt_d = '0;
                            for (int i = 0; i < 4; i++) duty_d[i] = slew(duty_q[i], tgt_eff[i]);
                        end else if (tick) begin
                            rcnt_d = rcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_SETTLED;
                    pcnt_d  = '0;
                    rcnt_d  = '0;
                end
            endcase
        end

        settled_d = (state_d == ST_SETTLED);
    end

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SETTLED;
            pcnt_q    <= '0;
            rcnt_q    <= '0;
            settled_q <= 1'b1;
            for (int i = 0; i < 4; i++) duty_q[i] <= 8'd0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            rcnt_q    <= rcnt_d;
            settled_q <= settled_d;
            for (int i = 0; i < 4; i++) duty_q[i] <= duty_d[i];
        end
    end

    assign red_duty   = duty_q[0];
    assign green_duty = duty_q[1];
    assign blue_duty  = duty_q[2];
    assign white_duty = duty_q[3];
    assign settled    = settled_q;

endmodule

// File: tb/tb_rgbw_fade_ramp.sv
// -----------------------------------------------------------------------------
// tb_rgbw_fade_ramp
//
// Two instances with PRESC=4 share all inputs: u_s1 (STEP=1) and u_s4
// (STEP=4). A behavioural model tracks each instance's duties and settled flag
// and a compare process checks them on every falling edge; directed sections
// add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_rgbw_fade_ramp;

    localparam int PRESC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fade_en = 1'b1;
    logic [7:0] rate = 8'd0;
    logic [7:0] tgt [4];
    logic       blank = 1'b0;
    logic [7:0] duty1 [4];
    logic [7:0] duty4 [4];
    logic       settled1, settled4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // model state: [instance][channel]
    int m_duty [2][4];
    bit m_ramp [2];
    int m_cyc  [2];
    int m_ticks[2];
    int m_step [2];

    always #5 clk = ~clk;

    rgbw_fade_ramp #(.PRESC(PRESC), .STEP(1)) u_s1 (
        .clk12(clk), .reset(reset), .fade_en(fade_en), .rate(rate),
        .red_tgt(tgt[0]), .green_tgt(tgt[1]), .blue_tgt(tgt[2]), .white_tgt(tgt[3]),
`ifdef RGBW_FADE_BLANK_EN
        .blank(blank),
`endif
        .red_duty(duty1[0]), .green_duty(duty1[1]), .blue_duty(duty1[2]), .white_duty(duty1[3]),
        .settled(settled1)
    );

    rgbw_fade_ramp #(.PRESC(PRESC), .STEP(4)) u_s4 (
        .clk12(clk), .reset(reset), .fade_en(fade_en), .rate(rate),
        .red_tgt(tgt[0]), .green_tgt(tgt[1]), .blue_tgt(tgt[2]), .white_tgt(tgt[3]),
`ifdef RGBW_FADE_BLANK_EN
        .blank(blank),
`endif
        .red_duty(duty4[0]), .green_duty(duty4[1]), .blue_duty(duty4[2]), .white_duty(duty4[3]),
        .settled(settled4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int eff_tgt(input int ch);
        return blank ? 0 : int'(tgt[ch]);
    endfunction

    task automatic model_edge(input int n);
        bit all_match;
        all_match = 1'b1;
        for (int ch = 0; ch < 4; ch++)
            if (m_duty[n][ch] != eff_tgt(ch)) all_match = 1'b0;
        if (!fade_en) begin
            for (int ch = 0; ch < 4; ch++) m_duty[n][ch] = eff_tgt(ch);
            m_ramp[n] = 1'b0;
        end else if (!m_ramp[n]) begin
            if (!all_match) begin
                m_ramp[n]  = 1'b1;
                m_cyc[n]   = 0;
                m_ticks[n] = 0;
            end
        end else if (all_match) begin
            m_ramp[n] = 1'b0;
        end else begin
            // a base tick every PRESC cycles after ramp entry; a step on the
            // tick that makes more than 'rate' ticks since the last step
            m_cyc[n]++;
            if (m_cyc[n] % PRESC == 0) begin
                m_ticks[n]++;
                if (m_ticks[n] > int'(rate)) begin
                    m_ticks[n] = 0;
                    for (int ch = 0; ch < 4; ch++) begin
                        int t, d, delta;
                        t = eff_tgt(ch);
                        d = m_duty[n][ch];
                        delta = (t > d) ? t - d : d - t;
                        if (delta > m_step[n]) delta = m_step[n];
                        m_duty[n][ch] = (t > d) ? d + delta : d - delta;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                for (int ch = 0; ch < 4; ch++) m_duty[n][ch] = 0;
                m_ramp[n] = 1'b0; m_cyc[n] = 0; m_ticks[n] = 0;
            end
        end else begin
            for (int n = 0; n < 2; n++) model_edge(n);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("s1_duty%0d", ch), int'(duty1[ch]), m_duty[0][ch]);
                check($sformatf("s4_duty%0d", ch), int'(duty4[ch]), m_duty[1][ch]);
            end
            check("s1_settled", int'(settled1), int'(!m_ramp[0]));
            check("s4_settled", int'(settled4), int'(!m_ramp[1]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_settled(input int max_cyc);
        int i;
        wait_edges(2);
        for (i = 0; i < max_cyc; i++) begin
            if (settled1 && settled4) break;
            @(negedge clk);
        end
        checks++;
        if (i >= max_cyc) begin
            errors++;
            $display("FAIL settle_timeout: got not settled after %0d cycles, required settled", max_cyc);
        end
    endtask

    task automatic set_tgts(input int r, input int g, input int b, input int w);
        tgt[0] = 8'(r); tgt[1] = 8'(g); tgt[2] = 8'(b); tgt[3] = 8'(w);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        m_step[0] = 1;
        m_step[1] = 4;
        set_tgts(3, 0, 0, 0);
        wait_edges(1);
        cmp_en = 1'b1;
        check("reset_s1_red", int'(duty1[0]), 0);
        check("reset_s1_settled", int'(settled1), 1);
        wait_edges(2);
        reset = 1'b0;

        // soft start: entry at edge 1, steps at edges 5, 9, 13
        wait_edges(1);
        check("ss_entry_s1_settled", int'(settled1), 0);
        check("ss_entry_s4_settled", int'(settled4), 0);
        wait_edges(4);
        check("ss_s1_red_step1", int'(duty1[0]), 1);
        check("ss_s4_red_step1", int'(duty4[0]), 3);
        check("ss_model_s1_red", m_duty[0][0], 1);
        wait_edges(1);
        check("ss_s4_settled", int'(settled4), 1);
        check("ss_s1_still_ramp", int'(settled1), 0);
        wait_edges(3);
        check("ss_s1_red_step2", int'(duty1[0]), 2);
        wait_edges(4);
        check("ss_s1_red_step3", int'(duty1[0]), 3);
        check("ss_s1_settled_late", int'(settled1), 0);
        wait_edges(1);
        check("ss_s1_settled", int'(settled1), 1);

        // STEP=4 down from 10 to 0: 6, 2, 0 without wrapping
        tgt[0] = 8'd10;
        wait_settled(200);
        tgt[0] = 8'd0;
        wait_edges(5);
        check("down_s4_red_6", int'(duty4[0]), 6);
        wait_edges(4);
        check("down_s4_red_2", int'(duty4[0]), 2);
        wait_edges(4);
        check("down_s4_red_0", int'(duty4[0]), 0);
        wait_edges(1);
        check("down_s4_settled", int'(settled4), 1);
        wait_settled(200);

        // direct tracking, then 1->0 mid-ramp and 0->1 with no change
        fade_en = 1'b0;
        tgt[1] = 8'd200;
        wait_edges(1);
        check("direct_s1_green", int'(duty1[1]), 200);
        check("direct_s4_green", int'(duty4[1]), 200);
        check("direct_s1_settled", int'(settled1), 1);
        fade_en = 1'b1;
        tgt[1] = 8'd0;
        wait_edges(10);
        check("midramp_s1_green", int'(duty1[1]), 198);
        check("midramp_s1_settled", int'(settled1), 0);
        fade_en = 1'b0;
        wait_edges(1);
        check("jump_s1_green", int'(duty1[1]), 0);
        check("jump_s1_settled", int'(settled1), 1);
        fade_en = 1'b1;
        wait_edges(2);
        check("reenable_s1_green", int'(duty1[1]), 0);
        check("reenable_s1_settled", int'(settled1), 1);

        // reversal mid-ramp: blue 0->50, redirected to 10 at 20
        tgt[2] = 8'd50;
        wait_edges(1);
        for (k = 0; k < 400; k++) begin
            if (duty1[2] == 8'd20) break;
            @(negedge clk);
        end
        check("rev_reach_20", int'(duty1[2]), 20);
        tgt[2] = 8'd10;
        wait_edges(4);
        check("rev_s1_blue_19", int'(duty1[2]), 19);
        wait_edges(4);
        check("rev_s1_blue_18", int'(duty1[2]), 18);
        wait_settled(400);
        check("rev_s1_blue_final", int'(duty1[2]), 10);
        check("rev_s4_blue_final", int'(duty4[2]), 10);

        // slow rate, then lowered while two ticks are counted
        rate = 8'd3;
        tgt[3] = 8'd5;
        wait_edges(16);
        check("rate3_no_step_yet", int'(duty1[3]), 0);
        wait_edges(1);
        check("rate3_s1_white_1", int'(duty1[3]), 1);
        check("rate3_s4_white_4", int'(duty4[3]), 4);
        wait_edges(8);
        rate = 8'd0;
        wait_edges(4);
        check("rate_drop_s1_white_2", int'(duty1[3]), 2);
        check("rate_drop_s4_white_5", int'(duty4[3]), 5);
        wait_settled(200);

`ifdef RGBW_FADE_BLANK_EN
        set_tgts(8, 8, 8, 8);
        wait_settled(200);
        blank = 1'b1;
        wait_settled(200);
        for (int ch = 0; ch < 4; ch++) check($sformatf("blank_s1_%0d", ch), int'(duty1[ch]), 0);
        blank = 1'b0;
        wait_settled(200);
        for (int ch = 0; ch < 4; ch++) check($sformatf("unblank_s4_%0d", ch), int'(duty4[ch]), 8);
        blank = 1'b1;
`endif

        // asynchronous reset mid-ramp
        set_tgts(100, 100, 100, 100);
        wait_edges(20);
        #3 reset = 1'b1;
        #1;
        check("arst_s1_red", int'(duty1[0]), 0);
        check("arst_s4_white", int'(duty4[3]), 0);
        check("arst_s1_settled", int'(settled1), 1);
        check("arst_s4_settled", int'(settled4), 1);
        wait_edges(2);
        blank = 1'b0;
        reset = 1'b0;
        wait_settled(1000);
        check("final_s1_red", int'(duty1[0]), 100);
        check("final_s4_blue", int'(duty4[2]), 100);

        wait_edges(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
